// File: rtl/prog_mem_loader_if.sv
// ---------------------------------------------------------------------------
// prog_mem_loader_if
// Bundles the download port, the fetch port and the status outputs of the
// writable program memory.
//   Download : load_start, load_base, load_len, ld_valid, ld_data -> block
//              ld_ready                                          <- block
//   Fetch    : fetch_en, fetch_addr                              -> block
//              fetch_data, fetch_valid, cpu_hold                 <- block
//   Status   : load_done, load_cksum                             <- block
// master = host/core side, slave = memory side.
// ADDR_W and DATA_W must match the parameters of the attached memory.
// ---------------------------------------------------------------------------
interface prog_mem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W:0]   load_len;
  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_ready;
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              cpu_hold;
  logic              load_done;
  logic [7:0]        load_cksum;

  modport master (
    output load_start, load_base, load_len, ld_valid, ld_data,
    output fetch_en, fetch_addr,
    input  ld_ready, fetch_data, fetch_valid, cpu_hold, load_done, load_cksum
  );

  modport slave (
    input  load_start, load_base, load_len, ld_valid, ld_data,
    input  fetch_en, fetch_addr,
    output ld_ready, fetch_data, fetch_valid, cpu_hold, load_done, load_cksum
  );
endinterface

// File: rtl/prog_mem_loader.sv
// ---------------------------------------------------------------------------
// prog_mem_loader
// Writable program memory for the 8-bit core. Instruction words arrive as
// bytes over a valid/ready port, are assembled MSB-first and written to an
// internal RAM. The core fetches through a 1-cycle-latency synchronous read
// port and is held off (cpu_hold) while a download is in progress.
// Ports:
//   clk   - single rising-edge clock
//   rst_n - asynchronous active-low reset (RAM contents are not reset)
//   bus   - prog_mem_loader_if.slave: download port, fetch port, load_done
//           pulse and mod-256 byte checksum of the current/last download
// Parameters:
//   ADDR_W - fetch/load address width
//   DATA_W - instruction width, multiple of 8
//   DEPTH  - implemented words, <= 2**ADDR_W
// ---------------------------------------------------------------------------
module prog_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input logic            clk,
  input logic            rst_n,
  prog_mem_loader_if.slave bus
);

  localparam int BPW    = DATA_W / 8;
  localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BPW - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_WORD  = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t            state_reg;
  logic              ld_ready_reg;
  logic              hold_reg;
  logic              done_reg;
  logic [7:0]        cksum_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [ADDR_W:0]   remaining_reg;
  logic [BIDX_W-1:0] byte_idx_reg;
  logic [DATA_W-1:0] word_buf_reg;
  logic [DATA_W-1:0] word_next;

  logic              fetch_valid_reg;
  logic              rd_ok_reg;
  logic [DATA_W-1:0] rd_word_reg;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic byte_take;
  logic mem_we;
  logic fetch_go;
  logic fetch_in_range;
  logic wr_in_range;

  // -------------------------------------------------------------------------
  // Byte assembly: every accepted byte enters the low lane and older lanes
  // move up one, so the first byte of a word ends up in the MSB lane.
  // -------------------------------------------------------------------------
  assign word_next[7:0] = bus.ld_data;

  genvar gi;
  generate
    for (gi = 1; gi < BPW; gi++) begin : g_lane
      assign word_next[gi*8 +: 8] = word_buf_reg[(gi-1)*8 +: 8];
    end
  endgenerate

  assign byte_take   = bus.ld_valid && ld_ready_reg;
  assign wr_in_range = ({1'b0, wr_addr_reg} < DEPTH_L);
  assign mem_we      = (state_reg == WRITE) && wr_in_range;

  // -------------------------------------------------------------------------
  // Download FSM. All outputs are registered and set on the transition into
  // the state that owns them.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ld_ready_reg  <= 1'b0;
      hold_reg      <= 1'b0;
      done_reg      <= 1'b0;
      cksum_reg     <= '0;
      wr_addr_reg   <= '0;
      remaining_reg <= '0;
      byte_idx_reg  <= '0;
      word_buf_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.load_start) begin
            cksum_reg    <= '0;
            byte_idx_reg <= '0;
            if (bus.load_len != '0) begin
              wr_addr_reg   <= bus.load_base;
              remaining_reg <= bus.load_len;
              ld_ready_reg  <= 1'b1;
              hold_reg      <= 1'b1;
              state_reg     <= RECV;
            end else begin
              // Empty download: report completion without stalling the core.
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
        end

        RECV: begin
          if (byte_take) begin
            word_buf_reg <= word_next;
            cksum_reg    <= cksum_reg + bus.ld_data;
            byte_idx_reg <= byte_idx_reg + 1'b1;
            if (byte_idx_reg == LAST_BYTE) begin
              ld_ready_reg <= 1'b0;
              state_reg    <= WRITE;
            end
          end
        end

        WRITE: begin
          // The RAM write itself happens in the memory block below.
          wr_addr_reg   <= (wr_addr_reg == LAST_ADDR) ? '0 : wr_addr_reg + 1'b1;
          remaining_reg <= remaining_reg - 1'b1;
          byte_idx_reg  <= '0;
          if (remaining_reg == ONE_WORD) begin
            hold_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            ld_ready_reg <= 1'b1;
            state_reg    <= RECV;
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          ld_ready_reg <= 1'b0;
          hold_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // RAM: plain write port and registered read port with no reset so the
  // array maps onto block RAM and keeps its contents across rst_n.
  // Fetches are refused while hold_reg is high, which covers every WRITE
  // cycle, so the two ports never touch the RAM in the same cycle.
  // -------------------------------------------------------------------------
  assign fetch_go       = bus.fetch_en && !hold_reg;
  assign fetch_in_range = ({1'b0, bus.fetch_addr} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr_reg[MEM_AW-1:0]] <= word_buf_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (fetch_go) begin
      rd_word_reg <= mem[bus.fetch_addr[MEM_AW-1:0]];
    end
  end

  // rd_ok_reg qualifies the unreset RAM output: it is cleared by reset and
  // by out-of-range fetches, giving fetch_data=0 in both cases while the
  // data path itself stays free of reset logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_reg <= 1'b0;
      rd_ok_reg       <= 1'b0;
    end else begin
      fetch_valid_reg <= fetch_go;
      if (fetch_go) begin
        rd_ok_reg <= fetch_in_range;
      end
    end
  end

  assign bus.fetch_data  = rd_ok_reg ? rd_word_reg : '0;
  assign bus.fetch_valid = fetch_valid_reg;
  assign bus.ld_ready    = ld_ready_reg;
  assign bus.cpu_hold    = hold_reg;
  assign bus.load_done   = done_reg;
  assign bus.load_cksum  = cksum_reg;

endmodule

// File: tb/tb_prog_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_mem_loader
// Directed bench for prog_mem_loader. dut1 uses the default parameters
// (ADDR_W=8, DATA_W=16, DEPTH=256); dut2 uses DATA_W=24, DEPTH=16.
// Inputs change 1 time unit after the rising edge and outputs are sampled
// at that same point, i.e. away from the active edge.
// ---------------------------------------------------------------------------
module tb_prog_mem_loader;

  logic clk;
  logic rst_n;

  prog_mem_loader_if #(.ADDR_W(8), .DATA_W(16)) bus1 ();
  prog_mem_loader_if #(.ADDR_W(8), .DATA_W(24)) bus2 ();

  prog_mem_loader #(.ADDR_W(8), .DATA_W(16), .DEPTH(256)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  prog_mem_loader #(.ADDR_W(8), .DATA_W(24), .DEPTH(16)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Results of the most recent drive_load call.
  logic [7:0] byte_q[$];
  int hold_cnt;
  int done_cnt;
  int done_cyc;
  int taken;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one download on dut1 feeding byte_q, and records how many cycles
  // cpu_hold was high, when load_done pulsed and how many bytes were taken.
  // gaps: drive ld_valid with the repeating pattern 1,0,0,1.
  // poke: issue a second load_start (different base/len) during RECV.
  task automatic drive_load(input logic [7:0] base, input logic [8:0] len,
                            input bit gaps, input bit poke);
    bit [3:0] pat = 4'b1001;
    bit accept;
    hold_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    taken    = 0;
    bus1.load_base  = base;
    bus1.load_len   = len;
    bus1.load_start = 1'b1;
    tick();
    bus1.load_start = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (bus1.cpu_hold) hold_cnt++;
      if (bus1.load_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      bus1.load_start = poke && (cyc == 1);
      if (poke && cyc == 1) begin
        bus1.load_base = 8'h50;
        bus1.load_len  = 9'd7;
      end
      if (taken < byte_q.size()) begin
        bus1.ld_valid = gaps ? pat[cyc % 4] : 1'b1;
        bus1.ld_data  = byte_q[taken];
      end else begin
        bus1.ld_valid = 1'b0;
      end
      accept = bus1.ld_valid && bus1.ld_ready;
      tick();
      if (accept) taken++;
    end
    bus1.ld_valid   = 1'b0;
    bus1.load_start = 1'b0;
    $display("load1 base=%02h len=%0d taken=%0d hold_cycles=%0d done_at=%0d pulses=%0d cksum=%02h",
             base, len, taken, hold_cnt, done_cyc, done_cnt, bus1.load_cksum);
  endtask

  task automatic fetch1(input logic [7:0] addr, output logic [15:0] data, output logic valid);
    bus1.fetch_en   = 1'b1;
    bus1.fetch_addr = addr;
    tick();
    data  = bus1.fetch_data;
    valid = bus1.fetch_valid;
    bus1.fetch_en = 1'b0;
    $display("fetch1 addr=%02h data=%04h valid=%0b", addr, data, valid);
  endtask

  task automatic fetch2(input logic [7:0] addr, output logic [23:0] data, output logic valid);
    bus2.fetch_en   = 1'b1;
    bus2.fetch_addr = addr;
    tick();
    data  = bus2.fetch_data;
    valid = bus2.fetch_valid;
    bus2.fetch_en = 1'b0;
    $display("fetch2 addr=%02h data=%06h valid=%0b", addr, data, valid);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bus1.ld_ready !== 1'b0) begin failures++; $display("FAIL reset_ld_ready: got %b want 0", bus1.ld_ready); end
    checks++; if (bus1.cpu_hold !== 1'b0) begin failures++; $display("FAIL reset_cpu_hold: got %b want 0", bus1.cpu_hold); end
    checks++; if (bus1.load_done !== 1'b0) begin failures++; $display("FAIL reset_load_done: got %b want 0", bus1.load_done); end
    checks++; if (bus1.fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_fetch_valid: got %b want 0", bus1.fetch_valid); end
    checks++; if (bus1.fetch_data !== 16'h0000) begin failures++; $display("FAIL reset_fetch_data: got %04h want 0000", bus1.fetch_data); end
    checks++; if (bus1.load_cksum !== 8'h00) begin failures++; $display("FAIL reset_load_cksum: got %02h want 00", bus1.load_cksum); end
    checks++; if (bus2.fetch_data !== 24'h0) begin failures++; $display("FAIL reset2_fetch_data: got %06h want 000000", bus2.fetch_data); end
    checks++; if (bus2.ld_ready !== 1'b0) begin failures++; $display("FAIL reset2_ld_ready: got %b want 0", bus2.ld_ready); end
    rst_n = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_basic_load();
    logic [15:0] d;
    logic v;
    byte_q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    drive_load(8'h03, 9'd2, 1'b0, 1'b0);
    // RECV,RECV,WRITE per word -> 6 hold cycles; DONE is sample 6.
    checks++; if (hold_cnt != 6) begin failures++; $display("FAIL basic_hold_cycles: got %0d want 6", hold_cnt); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
    checks++; if (done_cyc != 6) begin failures++; $display("FAIL basic_done_cycle: got %0d want 6", done_cyc); end
    checks++; if (taken != 4) begin failures++; $display("FAIL basic_bytes_taken: got %0d want 4", taken); end
    // 0x12+0x34+0xAB+0xCD = 0x1BE -> 0xBE mod 256
    checks++; if (bus1.load_cksum !== 8'hBE) begin failures++; $display("FAIL basic_cksum: got %02h want BE", bus1.load_cksum); end
    fetch1(8'h03, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h1234) begin failures++; $display("FAIL basic_fetch_03: got %04h/%b want 1234/1", d, v); end
    fetch1(8'h04, d, v);
    checks++; if (v !== 1'b1 || d !== 16'hABCD) begin failures++; $display("FAIL basic_fetch_04: got %04h/%b want ABCD/1", d, v); end
    tick();
    checks++; if (bus1.fetch_valid !== 1'b0 || bus1.fetch_data !== 16'hABCD) begin
      failures++; $display("FAIL basic_fetch_idle_hold: got %04h/%b want ABCD/0", bus1.fetch_data, bus1.fetch_valid);
    end
  endtask

  task automatic test_fetch_refused();
    bus1.load_base  = 8'h10;
    bus1.load_len   = 9'd1;
    bus1.load_start = 1'b1;
    tick();
    bus1.load_start = 1'b0;
    bus1.fetch_en   = 1'b1;
    bus1.fetch_addr = 8'h03;
    bus1.ld_valid   = 1'b1;
    bus1.ld_data    = 8'h55;
    tick();
    $display("fetch1 addr=03 during RECV data=%04h valid=%0b", bus1.fetch_data, bus1.fetch_valid);
    checks++; if (bus1.fetch_valid !== 1'b0) begin failures++; $display("FAIL refused_fetch_valid: got %b want 0", bus1.fetch_valid); end
    checks++; if (bus1.fetch_data !== 16'hABCD) begin failures++; $display("FAIL refused_fetch_data: got %04h want ABCD", bus1.fetch_data); end
    bus1.fetch_en = 1'b0;
    bus1.ld_data  = 8'h66;
    tick();
    bus1.ld_valid = 1'b0;
    tick();
    checks++; if (bus1.load_done !== 1'b1 || bus1.cpu_hold !== 1'b0) begin
      failures++; $display("FAIL refused_done_state: got done=%b hold=%b want 1/0", bus1.load_done, bus1.cpu_hold);
    end
    // Fetch issued in the DONE cycle must be accepted and see the new word.
    bus1.fetch_en   = 1'b1;
    bus1.fetch_addr = 8'h10;
    tick();
    bus1.fetch_en = 1'b0;
    $display("fetch1 addr=10 in DONE data=%04h valid=%0b", bus1.fetch_data, bus1.fetch_valid);
    checks++; if (bus1.fetch_valid !== 1'b1 || bus1.fetch_data !== 16'h5566) begin
      failures++; $display("FAIL done_cycle_fetch: got %04h/%b want 5566/1", bus1.fetch_data, bus1.fetch_valid);
    end
    checks++; if (bus1.load_done !== 1'b0) begin failures++; $display("FAIL done_single_cycle: got %b want 0", bus1.load_done); end
    tick();
  endtask

  task automatic test_wrap();
    logic [15:0] d;
    logic v;
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive_load(8'hFF, 9'd2, 1'b0, 1'b0);
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL wrap_done_pulses: got %0d want 1", done_cnt); end
    // 0x11+0x22+0x33+0x44 = 0xAA
    checks++; if (bus1.load_cksum !== 8'hAA) begin failures++; $display("FAIL wrap_cksum: got %02h want AA", bus1.load_cksum); end
    fetch1(8'hFF, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h1122) begin failures++; $display("FAIL wrap_fetch_ff: got %04h/%b want 1122/1", d, v); end
    fetch1(8'h00, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h3344) begin failures++; $display("FAIL wrap_fetch_00: got %04h/%b want 3344/1", d, v); end
  endtask

  task automatic test_backpressure();
    logic [15:0] d;
    logic v;
    // Extra bytes are offered: only one word (2 bytes) may be taken, and
    // the ignored second load_start (len 7) must not extend the download.
    byte_q = '{8'hA5, 8'h5A, 8'hEE, 8'hEE};
    drive_load(8'h20, 9'd1, 1'b1, 1'b1);
    checks++; if (taken != 2) begin failures++; $display("FAIL bp_bytes_taken: got %0d want 2", taken); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done_pulses: got %0d want 1", done_cnt); end
    // valid pattern 1,0,0,1: bytes at samples 0 and 3, WRITE at 4, DONE at 5
    checks++; if (done_cyc != 5) begin failures++; $display("FAIL bp_done_cycle: got %0d want 5", done_cyc); end
    checks++; if (hold_cnt != 5) begin failures++; $display("FAIL bp_hold_cycles: got %0d want 5", hold_cnt); end
    // 0xA5+0x5A = 0xFF
    checks++; if (bus1.load_cksum !== 8'hFF) begin failures++; $display("FAIL bp_cksum: got %02h want FF", bus1.load_cksum); end
    fetch1(8'h20, d, v);
    checks++; if (v !== 1'b1 || d !== 16'hA55A) begin failures++; $display("FAIL bp_fetch_20: got %04h/%b want A55A/1", d, v); end
  endtask

  task automatic test_zero_len();
    logic [15:0] d;
    logic v;
    byte_q = '{};
    drive_load(8'h03, 9'd0, 1'b0, 1'b0);
    checks++; if (done_cyc != 0) begin failures++; $display("FAIL zero_done_cycle: got %0d want 0", done_cyc); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt); end
    checks++; if (hold_cnt != 0) begin failures++; $display("FAIL zero_hold_cycles: got %0d want 0", hold_cnt); end
    checks++; if (bus1.load_cksum !== 8'h00) begin failures++; $display("FAIL zero_cksum: got %02h want 00", bus1.load_cksum); end
    fetch1(8'h03, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h1234) begin failures++; $display("FAIL zero_ram_03: got %04h/%b want 1234/1", d, v); end
    fetch1(8'h04, d, v);
    checks++; if (v !== 1'b1 || d !== 16'hABCD) begin failures++; $display("FAIL zero_ram_04: got %04h/%b want ABCD/1", d, v); end
  endtask

  task automatic test_reset_midload();
    logic [15:0] d;
    logic v;
    int pulses;
    byte_q = '{8'hBE, 8'hEF};
    drive_load(8'h09, 9'd1, 1'b0, 1'b0);
    bus1.load_base  = 8'h08;
    bus1.load_len   = 9'd3;
    bus1.load_start = 1'b1;
    tick();
    bus1.load_start = 1'b0;
    bus1.ld_valid   = 1'b1;
    bus1.ld_data    = 8'h01;
    tick();
    bus1.ld_data    = 8'h02;
    tick();
    bus1.ld_data    = 8'h03;
    tick();
    tick();
    bus1.ld_valid   = 1'b0;
    // word 1 written, byte 1 of word 2 held in the buffer
    checks++; if (bus1.cpu_hold !== 1'b1 || bus1.load_cksum !== 8'h06) begin
      failures++; $display("FAIL midload_before_reset: got hold=%b cksum=%02h want 1/06", bus1.cpu_hold, bus1.load_cksum);
    end
    rst_n = 1'b0;
    #1;
    $display("reset asserted mid-load hold=%0b ready=%0b cksum=%02h", bus1.cpu_hold, bus1.ld_ready, bus1.load_cksum);
    checks++; if (bus1.cpu_hold !== 1'b0) begin failures++; $display("FAIL midload_cpu_hold: got %b want 0", bus1.cpu_hold); end
    checks++; if (bus1.ld_ready !== 1'b0) begin failures++; $display("FAIL midload_ld_ready: got %b want 0", bus1.ld_ready); end
    checks++; if (bus1.load_cksum !== 8'h00) begin failures++; $display("FAIL midload_cksum: got %02h want 00", bus1.load_cksum); end
    checks++; if (bus1.fetch_data !== 16'h0000) begin failures++; $display("FAIL midload_fetch_data: got %04h want 0000", bus1.fetch_data); end
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (bus1.load_done) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus1.load_done) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL midload_no_done: got %0d pulses want 0", pulses); end
    fetch1(8'h08, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h0102) begin failures++; $display("FAIL midload_word1: got %04h/%b want 0102/1", d, v); end
    fetch1(8'h09, d, v);
    checks++; if (v !== 1'b1 || d !== 16'hBEEF) begin failures++; $display("FAIL midload_word2_old: got %04h/%b want BEEF/1", d, v); end
  endtask

  task automatic test_wide();
    logic [7:0] wb [3];
    logic [23:0] d;
    logic v;
    bit accept;
    int n;
    int dcyc;
    wb[0] = 8'h01; wb[1] = 8'h02; wb[2] = 8'h03;
    n = 0;
    dcyc = -1;
    bus2.load_base  = 8'h02;
    bus2.load_len   = 9'd1;
    bus2.load_start = 1'b1;
    tick();
    bus2.load_start = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (bus2.load_done) begin
        dcyc = cyc;
        break;
      end
      bus2.ld_valid = (n < 3);
      bus2.ld_data  = (n < 3) ? wb[n] : 8'h00;
      accept = bus2.ld_valid && bus2.ld_ready;
      tick();
      if (accept) n++;
    end
    bus2.ld_valid = 1'b0;
    $display("load2 base=02 len=1 taken=%0d done_at=%0d cksum=%02h", n, dcyc, bus2.load_cksum);
    // BPW=3: three RECV cycles and one WRITE, DONE at sample 4
    checks++; if (dcyc != 4) begin failures++; $display("FAIL wide_done_cycle: got %0d want 4", dcyc); end
    checks++; if (n != 3) begin failures++; $display("FAIL wide_bytes_taken: got %0d want 3", n); end
    checks++; if (bus2.load_cksum !== 8'h06) begin failures++; $display("FAIL wide_cksum: got %02h want 06", bus2.load_cksum); end
    tick();
    fetch2(8'h02, d, v);
    checks++; if (v !== 1'b1 || d !== 24'h010203) begin failures++; $display("FAIL wide_fetch_02: got %06h/%b want 010203/1", d, v); end
    fetch2(8'h20, d, v);
    checks++; if (v !== 1'b1 || d !== 24'h000000) begin failures++; $display("FAIL wide_fetch_oob: got %06h/%b want 000000/1", d, v); end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus1.load_start = 1'b0;
    bus1.load_base  = '0;
    bus1.load_len   = '0;
    bus1.ld_valid   = 1'b0;
    bus1.ld_data    = '0;
    bus1.fetch_en   = 1'b0;
    bus1.fetch_addr = '0;
    bus2.load_start = 1'b0;
    bus2.load_base  = '0;
    bus2.load_len   = '0;
    bus2.ld_valid   = 1'b0;
    bus2.ld_data    = '0;
    bus2.fetch_en   = 1'b0;
    bus2.fetch_addr = '0;

    test_reset();
    test_basic_load();
    test_fetch_refused();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_reset_midload();
    test_wide();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
